// File: rtl/hwpf_nl_issue_ctrl_pkg.sv
// Shared types, sizing constants and line-address helpers for the next-line prefetch issue controller.
package hwpf_nl_issue_ctrl_pkg;

    localparam int LANE_SIZE   = 64;
    localparam int QUEUE_DEPTH = 8;
    localparam int INSERTS     = 2;
    localparam int PEND_DEPTH  = 4;
    localparam int PAGE_SIZE   = 4096;
    localparam int TIMEOUT     = 64;
    localparam int ADDR_W      = 32;

    localparam int LINE_OFF_W  = $clog2(LANE_SIZE);
    localparam int PAGE_OFF_W  = $clog2(PAGE_SIZE);
    localparam int PEND_PTR_W  = $clog2(PEND_DEPTH);
    localparam int PEND_CNT_W  = PEND_PTR_W + 1;
    localparam int ROOM_W      = PEND_CNT_W + 1;
    localparam int TIMER_W     = $clog2(TIMEOUT);
    localparam int LANE_CNT_W  = $clog2(INSERTS + 1);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } hwpf_state_e;

    function automatic addr_t line_align(addr_t a);
        return {a[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

    function automatic addr_t next_line(addr_t a);
        return line_align(a) + addr_t'(LANE_SIZE);
    endfunction

endpackage

// File: rtl/hwpf_nl_issue_ctrl_if.sv
// Prefetch request channel towards L2: valid/ready request plus a completion pulse.
interface hwpf_nl_issue_ctrl_if;

    logic                          pf_valid_o;
    hwpf_nl_issue_ctrl_pkg::addr_t pf_addr_o;
    logic                          pf_ready_i;
    logic                          pf_rsp_i;

    modport master (output pf_valid_o, output pf_addr_o, input pf_ready_i, input pf_rsp_i);
    modport slave  (input pf_valid_o, input pf_addr_o, output pf_ready_i, output pf_rsp_i);

endinterface

// File: rtl/hwpf_nl_issue_ctrl_pend_buf.sv
// Circular buffer of pending prefetch candidates: up to INSERTS packed pushes and one pop per cycle.
module hwpf_nl_issue_ctrl_pend_buf
    import hwpf_nl_issue_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_flush,
    input  logic                  i_pop,
    input  logic [LANE_CNT_W-1:0] i_push_cnt,
    input  addr_t                 i_push_data [INSERTS],
    output addr_t                 o_head,
    output logic [PEND_CNT_W-1:0] o_count,
    output addr_t                 o_entries [PEND_DEPTH],
    output logic [PEND_DEPTH-1:0] o_valids
);

    addr_t                 r_mem [PEND_DEPTH];
    logic [PEND_PTR_W-1:0] r_rd;
    logic [PEND_PTR_W-1:0] r_wr;
    logic [PEND_CNT_W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int j = 0; j < PEND_DEPTH; j++) r_mem[j] <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < INSERTS; k++) begin
                if (k < int'(i_push_cnt)) r_mem[r_wr + PEND_PTR_W'(k)] <= i_push_data[k];
            end
            r_wr    <= r_wr + PEND_PTR_W'(i_push_cnt);
            if (i_pop) r_rd <= r_rd + PEND_PTR_W'(1);
            r_count <= r_count + PEND_CNT_W'(i_push_cnt) - PEND_CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [PEND_PTR_W-1:0] w_off;
        w_off = '0;
        for (int j = 0; j < PEND_DEPTH; j++) begin
            w_off        = PEND_PTR_W'(j) - r_rd;
            o_entries[j] = r_mem[j];
            o_valids[j]  = ({1'b0, w_off} < r_count);
        end
    end

endmodule

// File: rtl/hwpf_nl_issue_ctrl.sv
// Next-line prefetch issue scheduler: filters CPU-miss candidates, buffers survivors, issues them to L2.
module hwpf_nl_issue_ctrl
    import hwpf_nl_issue_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   enable_i,
    input  logic [INSERTS-1:0]     cpu_valid_i,
    input  addr_t                  cpu_addr_i [INSERTS],
    input  addr_t                  fifo_data_i [QUEUE_DEPTH],
    input  logic [QUEUE_DEPTH-1:0] fifo_valid_i,
    output logic [INSERTS-1:0]     fifo_take_o,
    output addr_t                  fifo_req_o [INSERTS],
    output logic                   fifo_flush_o,
    output logic                   fifo_lock_o,
    hwpf_nl_issue_ctrl_if.master   pf_if,
    output logic [15:0]            pf_drop_cnt_o
);

    // state    | meaning
    // IDLE     | nothing outstanding; pops the buffer head when one is present
    // REQ      | pf_valid_o held with a stable address until pf_ready_i
    // WAIT_RSP | request accepted; waits for pf_rsp_i or the timeout
    hwpf_state_e           r_state;
    hwpf_state_e           w_state_nxt;
    addr_t                 r_pf_addr;
    logic [TIMER_W-1:0]    r_timer;
    logic [15:0]           r_drop_cnt;

    addr_t                 w_cand [INSERTS];
    logic [INSERTS-1:0]    w_surv;
    addr_t                 w_pend_ent [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] w_pend_vld;
    addr_t                 w_head;
    logic [PEND_CNT_W-1:0] w_count;
    logic [ROOM_W-1:0]     w_room;
    logic [LANE_CNT_W-1:0] w_n_acc;
    logic [LANE_CNT_W-1:0] w_n_drop;
    logic                  w_pop;
    logic                  w_timeout;
    logic [16:0]           w_drop_sum;

    assign fifo_flush_o = flush_i;
    assign fifo_lock_o  = ~enable_i;

    for (genvar gi = 0; gi < INSERTS; gi++) begin : g_cand
        assign w_cand[gi] = next_line(cpu_addr_i[gi]);
    end

    always_comb begin
        w_surv = '0;
        for (int i = 0; i < INSERTS; i++) begin
            w_surv[i] = cpu_valid_i[i] & enable_i & ~flush_i;
            if (w_cand[i][ADDR_W-1:PAGE_OFF_W] != cpu_addr_i[i][ADDR_W-1:PAGE_OFF_W]) w_surv[i] = 1'b0;
            for (int q = 0; q < QUEUE_DEPTH; q++) begin
                if (fifo_valid_i[q] && (fifo_data_i[q] == w_cand[i])) w_surv[i] = 1'b0;
            end
            for (int p = 0; p < PEND_DEPTH; p++) begin
                if (w_pend_vld[p] && (w_pend_ent[p] == w_cand[i])) w_surv[i] = 1'b0;
            end
            if ((r_state != IDLE) && (r_pf_addr == w_cand[i])) w_surv[i] = 1'b0;
            for (int l = 0; l < i; l++) begin
                if (cpu_valid_i[l] && (w_cand[l] == w_cand[i])) w_surv[i] = 1'b0;
            end
        end
    end

    assign w_pop  = (r_state == IDLE) && (w_count != '0) && !flush_i;
    // A same-cycle pop frees a slot for this cycle's pushes.
    assign w_room = ROOM_W'(PEND_DEPTH) - ROOM_W'(w_count) + ROOM_W'(w_pop);

    always_comb begin
        int n_acc;
        int n_drop;
        n_acc       = 0;
        n_drop      = 0;
        fifo_take_o = '0;
        for (int k = 0; k < INSERTS; k++) fifo_req_o[k] = '0;
        for (int i = 0; i < INSERTS; i++) begin
            if (w_surv[i]) begin
                if (ROOM_W'(n_acc) < w_room) begin
                    for (int k = 0; k < INSERTS; k++) begin
                        if (k == n_acc) begin
                            fifo_take_o[k] = 1'b1;
                            fifo_req_o[k]  = w_cand[i];
                        end
                    end
                    n_acc = n_acc + 1;
                end else begin
                    n_drop = n_drop + 1;
                end
            end
        end
        w_n_acc  = LANE_CNT_W'(n_acc);
        w_n_drop = LANE_CNT_W'(n_drop);
    end

    hwpf_nl_issue_ctrl_pend_buf u_pend_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_flush     (flush_i),
        .i_pop       (w_pop),
        .i_push_cnt  (w_n_acc),
        .i_push_data (fifo_req_o),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_entries   (w_pend_ent),
        .o_valids    (w_pend_vld)
    );

    assign w_timeout = (r_state == WAIT_RSP) && !pf_if.pf_rsp_i && !flush_i &&
                       (r_timer == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_pop) w_state_nxt = REQ;
            REQ:      if (pf_if.pf_ready_i) w_state_nxt = WAIT_RSP;
            WAIT_RSP: if (pf_if.pf_rsp_i || w_timeout) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        if (flush_i) w_state_nxt = IDLE;
    end

    always_comb begin
        pf_if.pf_valid_o = (r_state == REQ);
        pf_if.pf_addr_o  = r_pf_addr;
    end

    assign w_drop_sum    = {1'b0, r_drop_cnt} + 17'(w_n_drop) + 17'(w_timeout);
    assign pf_drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pf_addr  <= '0;
            r_timer    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_pop) r_pf_addr <= w_head;
            if (flush_i || (r_state != WAIT_RSP)) r_timer <= '0;
            else                                 r_timer <= r_timer + 1'b1;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_hwpf_nl_issue_ctrl.sv
// Bench for the next-line prefetch issue controller: directed scenarios plus randomized traffic vs a queue model.
module tb_hwpf_nl_issue_ctrl;
    import hwpf_nl_issue_ctrl_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   flush_i;
    logic                   enable_i;
    logic [INSERTS-1:0]     cpu_valid_i;
    addr_t                  cpu_addr_i [INSERTS];
    addr_t                  fifo_data_i [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] fifo_valid_i;
    logic [INSERTS-1:0]     fifo_take_o;
    addr_t                  fifo_req_o [INSERTS];
    logic                   fifo_flush_o;
    logic                   fifo_lock_o;
    logic [15:0]            pf_drop_cnt_o;

    hwpf_nl_issue_ctrl_if pf_if ();

    hwpf_nl_issue_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .enable_i      (enable_i),
        .cpu_valid_i   (cpu_valid_i),
        .cpu_addr_i    (cpu_addr_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_valid_i  (fifo_valid_i),
        .fifo_take_o   (fifo_take_o),
        .fifo_req_o    (fifo_req_o),
        .fifo_flush_o  (fifo_flush_o),
        .fifo_lock_o   (fifo_lock_o),
        .pf_if         (pf_if),
        .pf_drop_cnt_o (pf_drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of waiting lines plus the outstanding request.
    addr_t m_pend[$];
    addr_t m_addr;
    bit    m_offer;
    bit    m_wait;
    int    m_wait_n;
    int    m_drop;

    logic [INSERTS-1:0] e_take;
    addr_t              e_req [INSERTS];
    addr_t              e_acc[$];
    int                 e_ndrop;
    bit                 e_pop;

    function automatic void model_reset();
        m_pend.delete();
        m_addr   = '0;
        m_offer  = 0;
        m_wait   = 0;
        m_wait_n = 0;
        m_drop   = 0;
    endfunction

    function automatic void model_eval();
        bit    busy;
        addr_t cand [INSERTS];
        busy = m_offer || m_wait;
        e_acc.delete();
        e_take  = '0;
        e_ndrop = 0;
        for (int k = 0; k < INSERTS; k++) e_req[k] = '0;
        e_pop = !busy && (m_pend.size() > 0) && !flush_i;
        for (int i = 0; i < INSERTS; i++)
            cand[i] = (cpu_addr_i[i] & ~addr_t'(LANE_SIZE - 1)) + addr_t'(LANE_SIZE);
        for (int i = 0; i < INSERTS; i++) begin
            bit kill;
            kill = !cpu_valid_i[i] || !enable_i || flush_i;
            if ((cand[i] >> PAGE_OFF_W) != (cpu_addr_i[i] >> PAGE_OFF_W)) kill = 1;
            for (int q = 0; q < QUEUE_DEPTH; q++)
                if (fifo_valid_i[q] && fifo_data_i[q] == cand[i]) kill = 1;
            foreach (m_pend[p]) if (m_pend[p] == cand[i]) kill = 1;
            if (busy && m_addr == cand[i]) kill = 1;
            for (int l = 0; l < i; l++)
                if (cpu_valid_i[l] && cand[l] == cand[i]) kill = 1;
            if (!kill) begin
                if (e_acc.size() < PEND_DEPTH - m_pend.size() + int'(e_pop)) e_acc.push_back(cand[i]);
                else e_ndrop++;
            end
        end
        foreach (e_acc[k]) begin
            e_take[k] = 1'b1;
            e_req[k]  = e_acc[k];
        end
    endfunction

    function automatic void model_commit();
        bit timeout;
        if (flush_i) begin
            m_pend.delete();
            m_offer  = 0;
            m_wait   = 0;
            m_wait_n = 0;
            return;
        end
        timeout = m_wait && !pf_if.pf_rsp_i && (m_wait_n == TIMEOUT - 1);
        m_drop  = m_drop + e_ndrop + int'(timeout);
        if (m_drop > 65535) m_drop = 65535;
        if (e_pop) begin
            m_addr  = m_pend.pop_front();
            m_offer = 1;
        end else if (m_offer && pf_if.pf_ready_i) begin
            m_offer  = 0;
            m_wait   = 1;
            m_wait_n = 0;
        end else if (m_wait) begin
            if (pf_if.pf_rsp_i || timeout) m_wait = 0;
            else m_wait_n++;
        end
        foreach (e_acc[k]) m_pend.push_back(e_acc[k]);
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk_i);
        model_commit();
        #2;
    endtask

    task automatic clear_inputs();
        flush_i          = 1'b0;
        enable_i         = 1'b1;
        cpu_valid_i      = '0;
        fifo_valid_i     = '0;
        pf_if.pf_ready_i = 1'b0;
        pf_if.pf_rsp_i   = 1'b0;
        for (int i = 0; i < INSERTS; i++) cpu_addr_i[i] = '0;
        for (int q = 0; q < QUEUE_DEPTH; q++) fifo_data_i[q] = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        model_reset();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #13;
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", pf_if.pf_valid_o); end
        checks++; if (pf_if.pf_addr_o !== '0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", pf_if.pf_addr_o); end
        checks++; if (pf_drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", pf_drop_cnt_o); end
        checks++; if (fifo_take_o !== 2'b00) begin errors++; $display("FAIL reset_take got=%b exp=00", fifo_take_o); end
        checks++; if ({fifo_flush_o, fifo_lock_o} !== 2'b00) begin errors++; $display("FAIL reset_flush_lock got=%b exp=00", {fifo_flush_o, fifo_lock_o}); end
        enable_i = 1'b0; #1;
        checks++; if (fifo_lock_o !== 1'b1) begin errors++; $display("FAIL lock_follows_enable got=%0b exp=1", fifo_lock_o); end
        do_reset();
    endtask

    task automatic test_single_miss();
        do_reset();
        pf_if.pf_ready_i = 1'b1;
        cpu_valid_i = 2'b01; cpu_addr_i[0] = 32'h1040; #1;
        checks++; if (fifo_take_o !== 2'b01) begin errors++; $display("FAIL single_take got=%b exp=01", fifo_take_o); end
        checks++; if (fifo_req_o[0] !== 32'h1080) begin errors++; $display("FAIL single_req got=%0h exp=1080", fifo_req_o[0]); end
        tick(); cpu_valid_i = '0; #1;
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL single_latency got=%0b exp=0", pf_if.pf_valid_o); end
        tick();
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h1080) begin errors++; $display("FAIL single_issue got=%0b/%0h exp=1/1080", pf_if.pf_valid_o, pf_if.pf_addr_o); end
        tick();
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL single_wait_valid got=%0b exp=0", pf_if.pf_valid_o); end
        cpu_valid_i = 2'b01; #1;
        checks++; if (fifo_take_o !== 2'b00) begin errors++; $display("FAIL single_inflight_filter got=%b exp=00", fifo_take_o); end
        cpu_valid_i = '0; pf_if.pf_rsp_i = 1'b1;
        tick();
        pf_if.pf_rsp_i = 1'b0; cpu_valid_i = 2'b01; #1;
        checks++; if (fifo_take_o !== 2'b01) begin errors++; $display("FAIL single_back_idle got=%b exp=01", fifo_take_o); end
        tick(); cpu_valid_i = '0;
    endtask

    task automatic test_filter();
        do_reset();
        pf_if.pf_ready_i = 1'b1;
        fifo_valid_i[0] = 1'b1; fifo_data_i[0] = 32'h1080;
        cpu_valid_i = 2'b01; cpu_addr_i[0] = 32'h1050; #1;
        checks++; if (fifo_take_o !== 2'b00) begin errors++; $display("FAIL filter_fifo_hit got=%b exp=00", fifo_take_o); end
        tick(); cpu_valid_i = '0; tick(); tick();
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL filter_no_issue got=%0b exp=0", pf_if.pf_valid_o); end
        fifo_valid_i = '0;
        cpu_valid_i = 2'b11; cpu_addr_i[0] = 32'h2000; cpu_addr_i[1] = 32'h2000; #1;
        checks++; if (fifo_take_o !== 2'b01 || fifo_req_o[0] !== 32'h2040) begin errors++; $display("FAIL filter_lane_dup got=%b/%0h exp=01/2040", fifo_take_o, fifo_req_o[0]); end
        tick(); cpu_valid_i = '0; tick();
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h2040) begin errors++; $display("FAIL filter_issue got=%0b/%0h exp=1/2040", pf_if.pf_valid_o, pf_if.pf_addr_o); end
        tick();
    endtask

    task automatic test_page_edge();
        do_reset();
        pf_if.pf_ready_i = 1'b1;
        cpu_valid_i = 2'b01; cpu_addr_i[0] = 32'h1FC0; #1;
        checks++; if (fifo_take_o !== 2'b00) begin errors++; $display("FAIL page_cross got=%b exp=00", fifo_take_o); end
        tick(); cpu_valid_i = '0; tick(); tick();
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL page_no_issue got=%0b exp=0", pf_if.pf_valid_o); end
        cpu_valid_i = 2'b01; cpu_addr_i[0] = 32'h1F80; #1;
        checks++; if (fifo_take_o !== 2'b01 || fifo_req_o[0] !== 32'h1FC0) begin errors++; $display("FAIL page_inside got=%b/%0h exp=01/1fc0", fifo_take_o, fifo_req_o[0]); end
        tick(); cpu_valid_i = '0; tick();
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h1FC0) begin errors++; $display("FAIL page_issue got=%0b/%0h exp=1/1fc0", pf_if.pf_valid_o, pf_if.pf_addr_o); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        pf_if.pf_ready_i = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cpu_valid_i = 2'b01; cpu_addr_i[0] = addr_t'(32'h3000 + n * 64); #1;
            if (n == 5) begin
                checks++; if (fifo_take_o !== 2'b00) begin errors++; $display("FAIL full_drop_take got=%b exp=00", fifo_take_o); end
            end else begin
                checks++; if (fifo_take_o !== 2'b01 || fifo_req_o[0] !== addr_t'(32'h3040 + n * 64)) begin errors++; $display("FAIL full_take n=%0d got=%b/%0h exp=01/%0h", n, fifo_take_o, fifo_req_o[0], 32'h3040 + n * 64); end
            end
            if (n >= 2) begin
                checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h3040) begin errors++; $display("FAIL full_stable n=%0d got=%0b/%0h exp=1/3040", n, pf_if.pf_valid_o, pf_if.pf_addr_o); end
            end
            tick();
        end
        cpu_valid_i = '0; #1;
        checks++; if (pf_drop_cnt_o !== 16'd1) begin errors++; $display("FAIL full_drop_cnt got=%0d exp=1", pf_drop_cnt_o); end
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h3040) begin errors++; $display("FAIL full_hold got=%0b/%0h exp=1/3040", pf_if.pf_valid_o, pf_if.pf_addr_o); end
    endtask

    task automatic test_timeout();
        pf_if.pf_ready_i = 1'b1; #1;
        tick();
        pf_if.pf_ready_i = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            checks++; if (pf_if.pf_valid_o !== 1'b0 || pf_drop_cnt_o !== 16'd1) begin errors++; $display("FAIL timeout_wait n=%0d got=%0b/%0d exp=0/1", n, pf_if.pf_valid_o, pf_drop_cnt_o); end
            tick();
        end
        checks++; if (pf_if.pf_valid_o !== 1'b0 || pf_drop_cnt_o !== 16'd2) begin errors++; $display("FAIL timeout_idle got=%0b/%0d exp=0/2", pf_if.pf_valid_o, pf_drop_cnt_o); end
        tick();
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h3080) begin errors++; $display("FAIL timeout_next got=%0b/%0h exp=1/3080", pf_if.pf_valid_o, pf_if.pf_addr_o); end
    endtask

    task automatic test_flush();
        pf_if.pf_ready_i = 1'b1; #1;
        tick();
        pf_if.pf_ready_i = 1'b0;
        flush_i = 1'b1; #1;
        checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL flush_fwd got=%0b exp=1", fifo_flush_o); end
        tick();
        flush_i = 1'b0; #1;
        checks++; if (pf_if.pf_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", pf_if.pf_valid_o); end
        pf_if.pf_rsp_i = 1'b1; tick(); pf_if.pf_rsp_i = 1'b0; tick();
        checks++; if (pf_if.pf_valid_o !== 1'b0 || pf_drop_cnt_o !== 16'd2) begin errors++; $display("FAIL flush_empty got=%0b/%0d exp=0/2", pf_if.pf_valid_o, pf_drop_cnt_o); end
        cpu_valid_i = 2'b01; cpu_addr_i[0] = 32'h30C0; #1;
        checks++; if (fifo_take_o !== 2'b01 || fifo_req_o[0] !== 32'h3100) begin errors++; $display("FAIL flush_buf_cleared got=%b/%0h exp=01/3100", fifo_take_o, fifo_req_o[0]); end
        tick(); cpu_valid_i = '0; tick();
        checks++; if (pf_if.pf_valid_o !== 1'b1 || pf_if.pf_addr_o !== 32'h3100) begin errors++; $display("FAIL flush_reissue got=%0b/%0h exp=1/3100", pf_if.pf_valid_o, pf_if.pf_addr_o); end
    endtask

    function automatic addr_t rand_addr();
        int unsigned pg;
        int unsigned ln;
        pg = $urandom_range(0, 1);
        ln = $urandom_range(0, 7);
        if (ln >= 4) ln = ln + 56;
        return addr_t'((pg << 12) | (ln << 6) | $urandom_range(0, 63));
    endfunction

    task automatic test_random();
        int rsp_pct;
        do_reset();
        rsp_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rsp_pct = ($urandom_range(0, 2) == 0) ? 0 : 20;
            flush_i          = ($urandom_range(0, 99) < 2);
            enable_i         = ($urandom_range(0, 9) != 0);
            pf_if.pf_ready_i = $urandom_range(0, 1) == 1;
            pf_if.pf_rsp_i   = ($urandom_range(0, 99) < rsp_pct);
            for (int i = 0; i < INSERTS; i++) begin
                cpu_valid_i[i] = $urandom_range(0, 1) == 1;
                cpu_addr_i[i]  = rand_addr();
            end
            for (int q = 0; q < QUEUE_DEPTH; q++) begin
                fifo_valid_i[q] = ($urandom_range(0, 3) == 0);
                fifo_data_i[q]  = rand_addr() & ~addr_t'(LANE_SIZE - 1);
            end
            #1;
            model_eval();
            checks++; if (fifo_take_o !== e_take) begin errors++; $display("FAIL rnd_take c=%0d got=%b exp=%b", c, fifo_take_o, e_take); end
            for (int k = 0; k < INSERTS; k++) begin
                if (e_take[k]) begin
                    checks++; if (fifo_req_o[k] !== e_req[k]) begin errors++; $display("FAIL rnd_req c=%0d k=%0d got=%0h exp=%0h", c, k, fifo_req_o[k], e_req[k]); end
                end
            end
            checks++; if (pf_if.pf_valid_o !== m_offer) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, pf_if.pf_valid_o, m_offer); end
            if (m_offer) begin
                checks++; if (pf_if.pf_addr_o !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, pf_if.pf_addr_o, m_addr); end
            end
            checks++; if (pf_drop_cnt_o !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, pf_drop_cnt_o, m_drop); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_miss();
        test_filter();
        test_page_edge();
        test_backpressure();
        test_timeout();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
